// File: rtl/seg7_scan_decoder_if.sv
// Bus between a multiplexed 7-segment display driver and the scan decoder
// that monitors it: sampled segment/select lines in, decoded frame results out.
interface seg7_scan_decoder_if;
  logic        enable;
  logic [6:0]  seg_in;
  logic [2:0]  digit_sel_in;
  logic [11:0] bcd_out;
  logic [9:0]  bin_out;
  logic        frame_valid;
  logic        frame_err;
  logic        sel_err;
  logic        stale;

  modport master (
    output enable, seg_in, digit_sel_in,
    input  bcd_out, bin_out, frame_valid, frame_err, sel_err, stale
  );

  modport slave (
    input  enable, seg_in, digit_sel_in,
    output bcd_out, bin_out, frame_valid, frame_err, sel_err, stale
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Receive-side monitor for a multiplexed 7-segment display: deghosts the
// segment/select bus, decodes each digit back to BCD and assembles frames.
module seg7_scan_decoder #(
  parameter int unsigned NUM_DIGITS     = 3,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input logic                clk,
  input logic                rst_n,
  seg7_scan_decoder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_SAT   = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_PRE   = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [TMO_W-1:0]      TMO_SAT   = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [NUM_DIGITS-1:0] MASK_FULL = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

  function automatic logic [3:0] seg_decode(input logic [6:0] p);
    case (p)
      7'h3F:   return 4'd0;
      7'h06:   return 4'd1;
      7'h5B:   return 4'd2;
      7'h4F:   return 4'd3;
      7'h66:   return 4'd4;
      7'h6D:   return 4'd5;
      7'h7D:   return 4'd6;
      7'h07:   return 4'd7;
      7'h7F:   return 4'd8;
      7'h6F:   return 4'd9;
      default: return 4'hF;
    endcase
  endfunction

  state_t                    state_q, state_d;
  logic [6:0]                seg_q, seg_d;
  logic [NUM_DIGITS-1:0]     sel_q, sel_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]     mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0]   nib_q, nib_d;
  logic [4*NUM_DIGITS-1:0]   bcd_q, bcd_d;
  logic [9:0]                bin_q, bin_d;
  logic                      fvalid_q, fvalid_d;
  logic                      ferr_q, ferr_d;
  logic                      selerr_q, selerr_d;
  logic [TMO_W-1:0]          tmo_q, tmo_d;
  logic                      stale_q, stale_d;

  logic       changed;
  logic       accept;
  logic       sel_bad;
  logic       any_bad;
  logic [3:0] nibble;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    nib_d    = nib_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    ferr_d   = ferr_q;
    tmo_d    = tmo_q;
    stale_d  = stale_q;
    fvalid_d = 1'b0;
    selerr_d = 1'b0;
    any_bad  = 1'b0;

    seg_d   = bus.seg_in;
    sel_d   = bus.digit_sel_in;
    changed = ({bus.seg_in, bus.digit_sel_in} != {seg_q, sel_q});
    cnt_d   = cnt_q;
    if (changed)
      cnt_d = '0;
    else if (cnt_q != CNT_SAT)
      cnt_d = cnt_q + 1'b1;

    // The sample is accepted exactly once per run: on the step from
    // STABLE_CYCLES-2 to STABLE_CYCLES-1; afterwards cnt saturates above it.
    accept  = bus.enable && !changed && (cnt_q == CNT_PRE);
    sel_bad = (sel_q != '0) && !$onehot(sel_q);
    nibble  = seg_decode(seg_q);

    if (!bus.enable) begin
      state_d = ST_IDLE;
      mask_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_SCAN: begin
          if (accept && sel_bad) begin
            selerr_d = 1'b1;
            mask_d   = '0;
            state_d  = ST_IDLE;
          end else if (accept && (sel_q != '0) && ((mask_q & sel_q) == '0)) begin
            mask_d = mask_q | sel_q;
            for (int unsigned i = 0; i < NUM_DIGITS; i++)
              if (sel_q[i]) nib_d[4*i +: 4] = nibble;
            state_d = (mask_d == MASK_FULL) ? ST_DONE : ST_SCAN;
          end
        end
        ST_DONE: begin
          for (int unsigned i = 0; i < NUM_DIGITS; i++)
            if (nib_q[4*i +: 4] == 4'hF) any_bad = 1'b1;
          bcd_d    = nib_q;
          fvalid_d = 1'b1;
          ferr_d   = any_bad;
          if (!any_bad)
            bin_d = 10'(nib_q[11:8]) * 10'd100 + 10'(nib_q[7:4]) * 10'd10
                  + 10'(nib_q[3:0]);
          mask_d  = '0;
          state_d = ST_IDLE;
        end
        default: begin
          mask_d  = '0;
          state_d = ST_IDLE;
        end
      endcase

      if (state_q == ST_DONE) begin
        tmo_d   = '0;
        stale_d = 1'b0;
      end else if (tmo_q != TMO_SAT) begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_d == TMO_SAT) stale_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      seg_q    <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      nib_q    <= '0;
      bcd_q    <= '0;
      bin_q    <= '0;
      fvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      selerr_q <= 1'b0;
      tmo_q    <= '0;
      stale_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      nib_q    <= nib_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      fvalid_q <= fvalid_d;
      ferr_q   <= ferr_d;
      selerr_q <= selerr_d;
      tmo_q    <= tmo_d;
      stale_q  <= stale_d;
    end
  end

  assign bus.bcd_out     = bcd_q;
  assign bus.bin_out     = bin_q;
  assign bus.frame_valid = fvalid_q;
  assign bus.frame_err   = ferr_q;
  assign bus.sel_err     = selerr_q;
  assign bus.stale       = stale_q;

endmodule
